data_mem_sized: RTL
===================

// Module: data_mem_sized
// PURPOSE
//  Byte-addressed data memory for the MEM stage of the 5-stage pipeline. Supports
//  byte/halfword/word stores with lane masking and sign- or zero-extended loads.
//  Flags misaligned accesses. Clears itself after reset.
//  Streams its contents to the debug unit through a valid/ready dump port.
// PARAMETERS
//  B   32  data width; fixed at 32 (lanes = 4 bytes)
//  W   7   byte-address width; depth = 2**(W-2) words (default 32 words)
// PORTS
//  i_clk          in   1    clock, all logic on rising edge
//  i_reset_n      in   1    synchronous reset, active-low
//  i_mem_read     in   1    load request
//  i_mem_write    in   1    store request (has priority over i_mem_read)
//  i_bhw          in   2    size: 00 byte, 01 halfword, 11 word, 10 treated as word
//  i_unsigned     in   1    load extension: 1 zero-extend, 0 sign-extend
//  i_addr         in   W    byte address
//  i_data         in   B    store data, right-aligned
//  o_data         out  B    load data, registered, extended
//  o_misaligned   out  1    registered: last access was misaligned (no effect on memory)
//  o_busy         out  1    high in CLEAR or DUMP; accesses ignored
//  i_dump_start   in   1    start dump, sampled in IDLE only
//  i_dump_ready   in   1    debug sink ready
//  o_dump_valid   out  1    o_dump_data/o_dump_addr valid
//  o_dump_addr    out  W-2  word index of o_dump_data
//  o_dump_data    out  B    memory word being dumped
//  o_dump_done    out  1    one-cycle pulse after last word accepted
// BEHAVIOUR
//  Reset (i_reset_n=0 at edge): state<=CLEAR, clr_ptr<=0.
//   o_data, o_misaligned, o_dump_valid, o_dump_done, o_dump_addr <= 0; o_busy <= 1.
//  FSM states:
//   CLEAR: writes 0 to word clr_ptr each cycle.
//    After the last word (2**(W-2)-1) -> IDLE; o_busy falls on that transition.
//   IDLE: serves accesses. i_dump_start=1 -> DUMP, ptr<=0, o_busy<=1.
//    With i_dump_start and an access in the same cycle, the access is served and
//    the dump starts next cycle.
//   DUMP: o_dump_valid=1; o_dump_data is the registered read of word ptr.
//    ptr advances only on valid&&ready; data/addr stay stable while ready=0.
//    Last word accepted -> o_dump_done=1 for 1 cycle, o_dump_valid<=0 -> IDLE.
//  Reset mid-CLEAR or mid-DUMP aborts it and restarts CLEAR from word 0.
//  Word index = i_addr[W-1:2]; lane = i_addr[1:0].
//  Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
//   The store is suppressed; o_misaligned<=1 next cycle; o_data holds its old value.
//   Aligned accesses clear o_misaligned.
//  Store (IDLE, aligned), 1-cycle write:
//   byte -> lane addr[1:0] <= i_data[7:0]
//   half -> lanes {addr[1],0}+1:+0 <= i_data[15:0]
//   word -> all lanes. Other lanes unchanged.
//  Load (IDLE, aligned, i_mem_write=0): o_data valid the cycle after the request.
//   byte/half are extracted from the addressed lanes, then sign- or zero-extended.
//   With no access, o_data holds its value.
//  A store and a load to the same word cannot co-occur (write has priority).
//   A load issued the cycle after a store returns the new data.
//  While o_busy=1, i_mem_read/i_mem_write are ignored, o_data holds, and
//   o_misaligned stays 0.
// TESTING
//  1 Reset then idle -> o_busy=1 for 32 cycles then 0.
//    Word loads of every address return 0x00000000.
//  2 SW 0x11223344 @0x08; SB 0xAB @0x09; LW @0x08 -> 0x1122AB44.
//    LBU @0x09 -> 0x000000AB; LB @0x09 -> 0xFFFFFFAB.
//  3 SH 0x8001 @0x12; LH @0x12 -> 0xFFFF8001; LHU @0x12 -> 0x00008001;
//    LW @0x10 -> 0x80010000.
//  4 SW @0x05 and LH @0x03 -> o_misaligned=1 each next cycle.
//    Memory unchanged; o_data holds its previous value.
//  5 Dump with i_dump_ready toggling 1,0,0,1 -> each word emitted once, in order.
//    Data/addr stable during stalls; o_dump_done pulses once after word 31.
//  6 Assert i_reset_n=0 mid-dump at ptr=10 -> CLEAR restarts.
//    After 32 cycles all words read 0; o_dump_valid=0 throughout.

Source files
------------

// File: rtl/data_mem_sized.sv
// Byte-addressed data memory for the MEM stage: sized stores with lane masking,
// extended loads, misalignment flag, self-clear after reset and a valid/ready dump port.
module data_mem_sized #(
    parameter int B = 32,
    parameter int W = 7
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_mem_read,
    input  logic         i_mem_write,
    input  logic [1:0]   i_bhw,
    input  logic         i_unsigned,
    input  logic [W-1:0] i_addr,
    input  logic [B-1:0] i_data,
    output logic [B-1:0] o_data,
    output logic         o_misaligned,
    output logic         o_busy,
    input  logic         i_dump_start,
    input  logic         i_dump_ready,
    output logic         o_dump_valid,
    output logic [W-3:0] o_dump_addr,
    output logic [B-1:0] o_dump_data,
    output logic         o_dump_done
);
    localparam int AW    = W - 2;
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_DUMP
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] dump_addr_q, dump_addr_d;
    logic          busy_q, busy_d;
    logic          dump_valid_q, dump_valid_d;
    logic          dump_done_q, dump_done_d;
    logic          mis_q, mis_d;
    logic [B-1:0]  data_q, data_d;
    logic          dump_load;

    logic [AW-1:0] acc_idx;
    logic [1:0]    acc_lane;
    logic          size_half, size_word, misalign, access, idle;
    logic          store_en, load_en;
    logic [3:0]    wr_be;
    logic [AW-1:0] wr_idx;
    logic [B-1:0]  wr_word;
    logic [B-1:0]  rd_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [B-1:0]  load_val;

    assign acc_idx   = i_addr[W-1:2];
    assign acc_lane  = i_addr[1:0];
    assign size_word = i_bhw[1];
    assign size_half = (i_bhw == 2'b01);
    assign misalign  = (size_half && i_addr[0]) || (size_word && (acc_lane != 2'b00));
    assign access    = i_mem_write || i_mem_read;
    assign idle      = (state_q == S_IDLE);
    assign store_en  = idle && i_mem_write && !misalign;
    assign load_en   = idle && !i_mem_write && i_mem_read && !misalign;

    // Single write port shared by the clear sweep and aligned stores.
    always_comb begin
        wr_be   = 4'b0000;
        wr_idx  = acc_idx;
        wr_word = i_data;
        if (state_q == S_CLEAR) begin
            wr_be   = 4'b1111;
            wr_idx  = ptr_q;
            wr_word = '0;
        end else if (store_en) begin
            case (i_bhw)
                2'b00: begin
                    wr_be   = 4'b0001 << acc_lane;
                    wr_word = {4{i_data[7:0]}};
                end
                2'b01: begin
                    wr_be   = i_addr[1] ? 4'b1100 : 4'b0011;
                    wr_word = {2{i_data[15:0]}};
                end
                default: begin
                    wr_be   = 4'b1111;
                    wr_word = i_data;
                end
            endcase
        end
        if (!i_reset_n) begin
            wr_be = 4'b0000;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] dump_byte_q;

            always_ff @(posedge i_clk) begin
                if (wr_be[gi]) begin
                    lane_mem[wr_idx] <= wr_word[gi*8 +: 8];
                end
            end

            always_ff @(posedge i_clk) begin
                if (dump_load) begin
                    dump_byte_q <= lane_mem[ptr_d];
                end
            end

            assign rd_word[gi*8 +: 8]     = lane_mem[acc_idx];
            assign o_dump_data[gi*8 +: 8] = dump_byte_q;
        end
    endgenerate

    always_comb begin
        ld_byte  = rd_word[{acc_lane, 3'b000} +: 8];
        ld_half  = i_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (i_bhw)
            2'b00:   load_val = {{24{~i_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   load_val = {{16{~i_unsigned & ld_half[15]}}, ld_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        dump_addr_d  = dump_addr_q;
        busy_d       = busy_q;
        dump_valid_d = dump_valid_q;
        dump_done_d  = 1'b0;
        mis_d        = mis_q;
        data_d       = data_q;
        dump_load    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mis_d = 1'b0;
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    ptr_d   = '0;
                end
            end
            S_IDLE: begin
                if (access) begin
                    mis_d = misalign;
                end
                if (load_en) begin
                    data_d = load_val;
                end
                if (i_dump_start) begin
                    state_d = S_DUMP;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                    mis_d   = 1'b0;
                end
            end
            S_DUMP: begin
                mis_d = 1'b0;
                // First DUMP cycle fetches word 0, so a store issued alongside the start is seen.
                if (!dump_valid_q) begin
                    dump_valid_d = 1'b1;
                    dump_load    = 1'b1;
                    dump_addr_d  = ptr_q;
                end else if (i_dump_ready) begin
                    if (ptr_q == LAST_IDX) begin
                        dump_valid_d = 1'b0;
                        dump_done_d  = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        ptr_d       = ptr_q + AW'(1);
                        dump_addr_d = ptr_q + AW'(1);
                        dump_load   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= S_CLEAR;
            ptr_q        <= '0;
            dump_addr_q  <= '0;
            busy_q       <= 1'b1;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            mis_q        <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            dump_addr_q  <= dump_addr_d;
            busy_q       <= busy_d;
            dump_valid_q <= dump_valid_d;
            dump_done_q  <= dump_done_d;
            mis_q        <= mis_d;
            data_q       <= data_d;
        end
    end

    assign o_data       = data_q;
    assign o_misaligned = mis_q;
    assign o_busy       = busy_q;
    assign o_dump_valid = dump_valid_q;
    assign o_dump_addr  = dump_addr_q;
    assign o_dump_done  = dump_done_q;

endmodule
